link_ctrl_nway: RTL and testbench



---
 rtl/link_ctrl_nway.sv | 219 +++++++++++++++++++++
 tb/tb_link_ctrl_nway.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_ctrl_nway.sv
// N-channel link controller: round-robin merge of per-NI send FIFOs onto the router
// link, and a type-mapped demux of router flits into per-NI receive FIFOs.

module link_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Show-ahead: head is visible without a pop; it reads as zero while empty.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rptr_q] : '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = ptr_next(wptr_q);
    if (do_pop)  rptr_d = ptr_next(rptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

module link_ctrl_nway #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_NI     = 4,
  parameter int CH_W       = 3,
  parameter int TYPE_LSB   = 16,
  parameter int TYPE_W     = 2,
  parameter logic [(2**TYPE_W)*CH_W-1:0] TYPE_MAP = {3'd3, 3'd2, 3'd1, 3'd0},
  parameter int NI_DEPTH   = 4,
  parameter int SBUF_DEPTH = 4,
  parameter int RBUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_WIDTH-1:0]        data_in,
  input  logic                         data_in_valid,
  output logic                         BP,
  output logic [FLIT_WIDTH-1:0]        data_out,
  output logic                         data_out_valid,
  input  logic                         BPo,
  input  logic [NUM_NI-1:0]            ni_we_sbuf,
  input  logic [NUM_NI*FLIT_WIDTH-1:0] ni_sdata,
  output logic [NUM_NI-1:0]            ni_sbuf_full,
  output logic [NUM_NI*FLIT_WIDTH-1:0] ni_rdata,
  output logic [NUM_NI-1:0]            ni_rdata_valid,
  input  logic [NUM_NI-1:0]            ni_re_rbuf,
  output logic [15:0]                  drop_cnt
);
  // Handshake: a flit moves on any edge where its producer shows valid and the
  // consumer is ready (router: BPo / BP; NIs: !ni_sbuf_full / ni_re_rbuf).

  logic [NUM_NI-1:0]     s_valid, s_full, s_pop;
  logic [FLIT_WIDTH-1:0] s_head [NUM_NI];
  logic [NUM_NI-1:0]     r_full, r_push;

  logic [FLIT_WIDTH-1:0] ls_head, ls_data, lr_head;
  logic                  ls_valid, ls_full, ls_push, ls_pop;
  logic                  lr_valid, lr_full, lr_pop;

  logic [CH_W-1:0]       last_q, last_d;
  int                    arb_best, arb_idx;
  logic                  grant;

  logic [TYPE_W-1:0]     rx_type;
  logic [CH_W-1:0]       rx_ch;
  logic                  rx_mapped, rx_blocked, rx_drop;
  logic [15:0]           drop_q, drop_d;

  for (genvar g = 0; g < NUM_NI; g++) begin : g_ni
    link_fifo #(.W(FLIT_WIDTH), .DEPTH(NI_DEPTH)) u_sbuf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ni_we_sbuf[g]),
      .data_i  (ni_sdata[g*FLIT_WIDTH +: FLIT_WIDTH]),
      .pop_i   (s_pop[g]),
      .head_o  (s_head[g]),
      .valid_o (s_valid[g]),
      .full_o  (s_full[g])
    );
    link_fifo #(.W(FLIT_WIDTH), .DEPTH(NI_DEPTH)) u_rbuf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (r_push[g]),
      .data_i  (lr_head),
      .pop_i   (ni_re_rbuf[g]),
      .head_o  (ni_rdata[g*FLIT_WIDTH +: FLIT_WIDTH]),
      .valid_o (ni_rdata_valid[g]),
      .full_o  (r_full[g])
    );
  end

  link_fifo #(.W(FLIT_WIDTH), .DEPTH(SBUF_DEPTH)) u_link_sbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ls_push),
    .data_i  (ls_data),
    .pop_i   (ls_pop),
    .head_o  (ls_head),
    .valid_o (ls_valid),
    .full_o  (ls_full)
  );

  link_fifo #(.W(FLIT_WIDTH), .DEPTH(RBUF_DEPTH)) u_link_rbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (data_in_valid),
    .data_i  (data_in),
    .pop_i   (lr_pop),
    .head_o  (lr_head),
    .valid_o (lr_valid),
    .full_o  (lr_full)
  );

  assign ni_sbuf_full   = s_full;
  assign data_out       = ls_head;
  assign data_out_valid = ls_valid;
  assign ls_pop         = ls_valid && BPo;
  assign BP             = !lr_full;
  assign drop_cnt       = drop_q;

  // Round-robin: the requester closest after last_q (cyclic distance) wins.
  // ls_full is pre-pop occupancy, so a same-cycle router pop never frees a slot.
  always_comb begin
    arb_best = NUM_NI;
    arb_idx  = 0;
    for (int i = 0; i < NUM_NI; i++) begin
      if (s_valid[i] && (((i + NUM_NI - 1 - int'(last_q)) % NUM_NI) < arb_best)) begin
        arb_best = (i + NUM_NI - 1 - int'(last_q)) % NUM_NI;
        arb_idx  = i;
      end
    end
    grant   = (arb_best < NUM_NI) && !ls_full;
    s_pop   = '0;
    ls_data = '0;
    last_d  = last_q;
    for (int i = 0; i < NUM_NI; i++) begin
      if (grant && (arb_idx == i)) begin
        s_pop[i] = 1'b1;
        ls_data  = s_head[i];
      end
    end
    if (grant) last_d = CH_W'(arb_idx);
    ls_push = grant;
  end

  // Receive demux: a mapped head waits for its NI (head-of-line blocking),
  // an unmapped head is discarded immediately.
  always_comb begin
    rx_type = lr_head[TYPE_LSB +: TYPE_W];
    rx_ch   = '0;
    for (int t = 0; t < 2**TYPE_W; t++) begin
      if (rx_type == TYPE_W'(t)) rx_ch = TYPE_MAP[t*CH_W +: CH_W];
    end
    rx_mapped  = (rx_ch < CH_W'(NUM_NI));
    r_push     = '0;
    rx_blocked = 1'b0;
    for (int i = 0; i < NUM_NI; i++) begin
      if (lr_valid && rx_mapped && (rx_ch == CH_W'(i))) begin
        if (r_full[i]) rx_blocked = 1'b1;
        else           r_push[i]  = 1'b1;
      end
    end
    lr_pop  = lr_valid && !rx_blocked;
    rx_drop = lr_valid && !rx_mapped;
    drop_d  = drop_q;
    if (rx_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= CH_W'(NUM_NI - 1);
      drop_q <= '0;
    end else begin
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_link_ctrl_nway.sv
// Randomised and directed bench for link_ctrl_nway against a queue-based model.
module tb_link_ctrl_nway;
  localparam int W    = 32;
  localparam int NI   = 4;
  localparam int NID  = 4;
  localparam int SBD  = 4;
  localparam int RBD  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    data_in;
  logic            data_in_valid;
  logic            BP;
  logic [W-1:0]    data_out;
  logic            data_out_valid;
  logic            BPo;
  logic [NI-1:0]   ni_we_sbuf;
  logic [NI*W-1:0] ni_sdata;
  logic [NI-1:0]   ni_sbuf_full;
  logic [NI*W-1:0] ni_rdata;
  logic [NI-1:0]   ni_rdata_valid;
  logic [NI-1:0]   ni_re_rbuf;
  logic [15:0]     drop_cnt;

  link_ctrl_nway #(
    .FLIT_WIDTH(W), .NUM_NI(NI), .CH_W(3), .TYPE_LSB(16), .TYPE_W(2),
    .TYPE_MAP({3'd4, 3'd2, 3'd1, 3'd0}),
    .NI_DEPTH(NID), .SBUF_DEPTH(SBD), .RBUF_DEPTH(RBD)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .BP(BP),
    .data_out(data_out), .data_out_valid(data_out_valid), .BPo(BPo),
    .ni_we_sbuf(ni_we_sbuf), .ni_sdata(ni_sdata), .ni_sbuf_full(ni_sbuf_full),
    .ni_rdata(ni_rdata), .ni_rdata_valid(ni_rdata_valid), .ni_re_rbuf(ni_re_rbuf),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_nsq [NI][$];
  logic [W-1:0] m_lrq[$];
  logic [W-1:0] m_nrq [NI][$];
  int           m_last;
  int           m_drop;
  int           tmap [4] = '{0, 1, 2, 4};

  int n_vec = 0;
  int n_err = 0;
  int seq   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int           gi, dlv, c;
    bit           drp, out_pop, rx_acc;
    bit [NI-1:0]  s_acc;
    logic [W-1:0] f;
    if (rst) begin
      exp_q.delete();
      m_lrq.delete();
      for (int i = 0; i < NI; i++) begin
        m_nsq[i].delete();
        m_nrq[i].delete();
      end
      m_last = NI - 1;
      m_drop = 0;
      return;
    end
    out_pop = (exp_q.size() > 0) && BPo;
    rx_acc  = data_in_valid && (m_lrq.size() < RBD);
    for (int i = 0; i < NI; i++) s_acc[i] = ni_we_sbuf[i] && (m_nsq[i].size() < NID);
    gi = -1;
    if (exp_q.size() < SBD) begin
      for (int k = 1; k <= NI; k++) begin
        int idx;
        idx = (m_last + k) % NI;
        if (gi < 0 && m_nsq[idx].size() > 0) gi = idx;
      end
    end
    dlv = -1;
    drp = 1'b0;
    if (m_lrq.size() > 0) begin
      f = m_lrq[0];
      c = tmap[f[17:16]];
      if (c >= NI) drp = 1'b1;
      else if (m_nrq[c].size() < NID) dlv = c;
    end
    if (out_pop) void'(exp_q.pop_front());
    if (gi >= 0) begin
      exp_q.push_back(m_nsq[gi].pop_front());
      m_last = gi;
    end
    for (int i = 0; i < NI; i++)
      if (ni_re_rbuf[i] && m_nrq[i].size() > 0) void'(m_nrq[i].pop_front());
    if (dlv >= 0) m_nrq[dlv].push_back(m_lrq.pop_front());
    else if (drp) begin
      void'(m_lrq.pop_front());
      if (m_drop < 65535) m_drop++;
    end
    for (int i = 0; i < NI; i++)
      if (s_acc[i]) m_nsq[i].push_back(ni_sdata[i*W +: W]);
    if (rx_acc) m_lrq.push_back(data_in);
  endtask

  task automatic check_outputs();
    logic [NI-1:0] e_sf, e_rv;
    logic [W-1:0]  e_rd;
    check_eq("dout_valid", data_out_valid, exp_q.size() > 0);
    check_eq("dout", data_out, (exp_q.size() > 0) ? exp_q[0] : '0);
    check_eq("bp", BP, m_lrq.size() < RBD);
    for (int i = 0; i < NI; i++) begin
      e_sf[i] = (m_nsq[i].size() == NID);
      e_rv[i] = (m_nrq[i].size() > 0);
    end
    check_eq("sbuf_full", ni_sbuf_full, e_sf);
    check_eq("rdata_valid", ni_rdata_valid, e_rv);
    for (int i = 0; i < NI; i++) begin
      e_rd = (m_nrq[i].size() > 0) ? m_nrq[i][0] : '0;
      check_eq("rdata", ni_rdata[i*W +: W], e_rd);
    end
    check_eq("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    data_in       = '0;
    data_in_valid = 1'b0;
    ni_we_sbuf    = '0;
    ni_sdata      = '0;
    ni_re_rbuf    = '0;
  endtask

  task automatic all_ni_write();
    ni_we_sbuf = '1;
    for (int i = 0; i < NI; i++) begin
      seq++;
      ni_sdata[i*W +: W] = {8'(i), 8'h5A, 16'(seq)};
    end
  endtask

  task automatic rx_send(input int t);
    seq++;
    data_in       = {14'h0, 2'(t), 16'(seq)};
    data_in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    BPo = 1'b1;
    idle_inputs();
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1;
    end
    rst = 1'b0;

    // Idle after reset
    repeat (3) tick();

    // Single NI0 flit
    ni_we_sbuf[0] = 1'b1;
    ni_sdata[W-1:0] = 32'hA0;
    tick();
    idle_inputs();
    repeat (5) tick();

    // Preload 3 flits per NI, then drain round-robin
    BPo = 1'b0;
    repeat (3) begin
      all_ni_write();
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    BPo = 1'b1;
    repeat (16) tick();

    // Type map: types 0..3, type 3 is dropped
    for (int t = 0; t < 4; t++) begin
      rx_send(t);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    ni_re_rbuf = '1;
    repeat (3) tick();
    idle_inputs();

    // Head-of-line blocking on a full NI1 receive FIFO
    repeat (NID) begin
      rx_send(1);
      tick();
    end
    rx_send(1);
    tick();
    repeat (6) begin
      rx_send(0);
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    ni_re_rbuf[1] = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    ni_re_rbuf = '1;
    repeat (12) tick();
    idle_inputs();

    // Router stalled while all NIs keep writing
    BPo = 1'b0;
    repeat (10) begin
      all_ni_write();
      tick();
    end
    idle_inputs();
    BPo = 1'b1;
    repeat (30) tick();

    // Random traffic with one mid-operation reset
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ni_we_sbuf    = NI'($urandom_range(0, 15));
      for (int i = 0; i < NI; i++) ni_sdata[i*W +: W] = $urandom;
      data_in_valid = ($urandom_range(0, 2) != 0);
      data_in       = $urandom;
      BPo           = ($urandom_range(0, 3) != 0);
      ni_re_rbuf    = NI'($urandom_range(0, 15));
      rst           = (cyc == 700);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    BPo = 1'b1;
    ni_re_rbuf = '1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
